// File: rtl/led_level_sequencer.sv
// Go Board LED bar controller: debounced switch releases drive a 2-bit level
// in manual, wrap-around sweep or ping-pong bounce mode.
module led_level_sequencer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_TICKS     = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [1:0] o_Select,
  output logic [1:0] o_Mode,
  output logic       o_Paused,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  // state       | meaning
  // MODE_MANUAL | SW2 release steps the level
  // MODE_SWEEP  | tick timer steps level 0..3 with wrap
  // MODE_BOUNCE | tick timer steps level 0..3..0 ping-pong
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SWEEP  = 2'b01,
    MODE_BOUNCE = 2'b10
  } mode_e;

  localparam int DW = $clog2(DEBOUNCE_LIMIT);
  localparam int TW = $clog2(STEP_TICKS);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(STEP_TICKS - 1);

  logic [1:0]         sw_raw;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_dly_q, deb_dly_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         rel_q, rel_d;
  mode_e              mode_q, mode_d;
  logic [1:0]         level_q, level_d;
  logic               paused_q, paused_d;
  logic               dir_up_q, dir_up_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               tick_tc;

  assign sw_raw  = {i_Switch_2, i_Switch_1};
  assign tick_tc = (tick_q == TICK_MAX);

  always_comb begin
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    deb_dly_d = deb_q;
    rel_d     = deb_dly_q & ~deb_q;
    for (int i = 0; i < 2; i++) begin
      if (sw_raw[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        deb_d[i] = sw_raw[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    mode_d   = mode_q;
    level_d  = level_q;
    paused_d = paused_q;
    dir_up_d = dir_up_q;
    tick_d   = tick_q;

    // A mode change takes priority over any SW2 event or timer step.
    if (rel_q[0]) begin
      case (mode_q)
        MODE_MANUAL: mode_d = MODE_SWEEP;
        MODE_SWEEP:  mode_d = MODE_BOUNCE;
        default:     mode_d = MODE_MANUAL;
      endcase
      tick_d   = '0;
      paused_d = 1'b0;
      dir_up_d = 1'b1;
    end else if (mode_q == MODE_MANUAL) begin
      tick_d = '0;
      if (rel_q[1]) level_d = level_q + 2'd1;
    end else if (paused_q) begin
      if (rel_q[1]) paused_d = 1'b0;
    end else begin
      if (rel_q[1]) paused_d = 1'b1;
      if (!tick_tc) begin
        tick_d = tick_q + 1'b1;
      end else begin
        tick_d = '0;
        if (mode_q == MODE_SWEEP) begin
          level_d = level_q + 2'd1;
        end else if (dir_up_q) begin
          // Entering bounce at level 3 with direction up turns straight around.
          if (level_q == 2'd3) begin
            level_d  = 2'd2;
            dir_up_d = 1'b0;
          end else begin
            level_d = level_q + 2'd1;
            if (level_q == 2'd2) dir_up_d = 1'b0;
          end
        end else begin
          if (level_q == 2'd0) begin
            level_d  = 2'd1;
            dir_up_d = 1'b1;
          end else begin
            level_d = level_q - 2'd1;
            if (level_q == 2'd1) dir_up_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      mode_q    <= MODE_MANUAL;
      level_q   <= '0;
      paused_q  <= 1'b0;
      dir_up_q  <= 1'b1;
      tick_q    <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      paused_q  <= paused_d;
      dir_up_q  <= dir_up_d;
      tick_q    <= tick_d;
    end
  end

  assign o_Select = level_q;
  assign o_Mode   = mode_q;
  assign o_Paused = paused_q;
  assign o_LED_1  = 1'b1;
  assign o_LED_2  = |level_q;
  assign o_LED_3  = level_q[1];
  assign o_LED_4  = &level_q;

endmodule

// File: tb/tb_led_level_sequencer.sv
// Self-checking bench for led_level_sequencer: directed scenarios plus
// randomized switch activity against a behavioural model.
module tb_led_level_sequencer;
  localparam int DL = 4;
  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       i_Rst, i_Switch_1, i_Switch_2;
  logic [1:0] o_Select, o_Mode;
  logic       o_Paused, o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [3:0] leds;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  led_level_sequencer #(.DEBOUNCE_LIMIT(DL), .STEP_TICKS(ST)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Switch_1(i_Switch_1), .i_Switch_2(i_Switch_2),
    .o_Select(o_Select), .o_Mode(o_Mode), .o_Paused(o_Paused),
    .o_LED_1(o_LED_1), .o_LED_2(o_LED_2), .o_LED_3(o_LED_3), .o_LED_4(o_LED_4)
  );

  // Behavioural model: switch timestamps, event pipeline, step counting.
  int m_mode = 0, m_level = 0, m_phase = 0, m_elapsed = 0, edge_no = 0;
  bit m_paused = 0;
  bit m_deb[2], m_fell[2], m_rel[2];
  int m_since[2];

  function automatic logic [3:0] therm(input int l);
    case (l)
      0: return 4'b0001;
      1: return 4'b0011;
      2: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit s1, input bit s2);
    bit raw[2];
    bit ev[2];
    raw[0] = s1; raw[1] = s2;
    edge_no++;
    if (rst) begin
      m_mode = 0; m_level = 0; m_phase = 0; m_elapsed = 0; m_paused = 0;
      for (int i = 0; i < 2; i++) begin
        m_deb[i] = 0; m_since[i] = -1; m_fell[i] = 0; m_rel[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      ev[i] = m_rel[i];
      m_rel[i] = m_fell[i];
      m_fell[i] = 0;
      if (raw[i] == m_deb[i]) m_since[i] = -1;
      else begin
        if (m_since[i] < 0) m_since[i] = edge_no;
        if (edge_no - m_since[i] + 1 >= DL) begin
          m_fell[i] = m_deb[i];
          m_deb[i] = raw[i];
          m_since[i] = -1;
        end
      end
    end
    if (ev[0]) begin
      m_mode = (m_mode + 1) % 3; m_elapsed = 0; m_paused = 0; m_phase = m_level;
    end else if (m_mode == 0) begin
      m_elapsed = 0;
      if (ev[1]) m_level = (m_level + 1) % 4;
    end else if (m_paused) begin
      if (ev[1]) m_paused = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed == ST) begin
        m_elapsed = 0;
        if (m_mode == 1) m_level = (m_level + 1) % 4;
        else begin
          m_phase = (m_phase + 1) % 6;
          m_level = (m_phase <= 3) ? m_phase : 6 - m_phase;
        end
      end
      if (ev[1]) m_paused = 1;
    end
  endtask

  task automatic cyc(input logic r, input logic s1, input logic s2);
    i_Rst = r; i_Switch_1 = s1; i_Switch_2 = s2;
    @(posedge clk);
    model_edge(r, s1, s2);
    @(negedge clk);
  endtask

  task automatic hold(input logic s1, input logic s2, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, s1, s2);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++; if (o_Select !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", o_Select); end
    n_checks++; if (leds !== 4'b0001) begin n_fail++; $display("FAIL reset_leds: got %b want 0001", leds); end
    n_checks++; if (o_Mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", o_Mode); end
    n_checks++; if (o_Paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %0d want 0", o_Paused); end
  endtask

  task automatic test_manual();
    int exp_sel[5] = '{1, 2, 3, 0, 1};
    logic [3:0] exp_led[5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011};
    for (int n = 0; n < 5; n++) begin
      logic [1:0] prev;
      int found;
      hold(1'b0, 1'b1, 10);
      prev = o_Select; found = 0;
      for (int k = 1; k <= 10; k++) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (found == 0 && o_Select !== prev) found = k;
      end
      n_checks++; if (found != DL + 2) begin n_fail++; $display("FAIL manual_latency: got %0d want %0d", found, DL + 2); end
      n_checks++; if (o_Select !== 2'(exp_sel[n])) begin n_fail++; $display("FAIL manual_sel: got %0d want %0d", o_Select, exp_sel[n]); end
      n_checks++; if (leds !== exp_led[n]) begin n_fail++; $display("FAIL manual_leds: got %b want %b", leds, exp_led[n]); end
    end
  endtask

  task automatic test_glitch();
    int base;
    base = int'(o_Select);
    hold(1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 10);
    n_checks++; if (o_Select !== 2'(base)) begin n_fail++; $display("FAIL glitch_press: got %0d want %0d", o_Select, base); end
    hold(1'b0, 1'b1, 10);
    for (int g = 0; g < 2; g++) begin
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 3);
    end
    hold(1'b0, 1'b1, 4);
    n_checks++; if (o_Select !== 2'(base)) begin n_fail++; $display("FAIL glitch_release: got %0d want %0d", o_Select, base); end
    hold(1'b0, 1'b0, 10);
    n_checks++; if (o_Select !== 2'((base + 1) % 4)) begin n_fail++; $display("FAIL glitch_stable1: got %0d want %0d", o_Select, (base + 1) % 4); end
    hold(1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 10);
    n_checks++; if (o_Select !== 2'((base + 2) % 4)) begin n_fail++; $display("FAIL glitch_stable2: got %0d want %0d", o_Select, (base + 2) % 4); end
  endtask

  task automatic test_sweep_pause();
    int found;
    logic [1:0] held;
    cyc(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin hold(1'b0, 1'b1, 6); hold(1'b0, 1'b0, 8); end
    n_checks++; if (o_Select !== 2'd2) begin n_fail++; $display("FAIL sweep_start: got %0d want 2", o_Select); end
    hold(1'b1, 1'b0, 6);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Mode === 2'd1) found = 1;
    end
    n_checks++; if (found != 1 || o_Select !== 2'd2) begin n_fail++; $display("FAIL sweep_enter: found %0d sel %0d want mode 1 sel 2", found, o_Select); end
    for (int n = 1; n <= 24; n++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (n == 7) begin n_checks++; if (o_Select !== 2'd2) begin n_fail++; $display("FAIL sweep_pre: got %0d want 2", o_Select); end end
      if (n == 8) begin n_checks++; if (o_Select !== 2'd3) begin n_fail++; $display("FAIL sweep_8: got %0d want 3", o_Select); end end
      if (n == 16) begin n_checks++; if (o_Select !== 2'd0) begin n_fail++; $display("FAIL sweep_16: got %0d want 0", o_Select); end end
      if (n == 24) begin n_checks++; if (o_Select !== 2'd1) begin n_fail++; $display("FAIL sweep_24: got %0d want 1", o_Select); end end
    end
    hold(1'b0, 1'b1, 5);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Paused === 1'b1) found = 1;
    end
    n_checks++; if (found != 1) begin n_fail++; $display("FAIL sweep_pause: paused %0d want 1", o_Paused); end
    held = o_Select;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_checks++; if (o_Select !== held || o_Select !== 2'(m_level)) begin n_fail++; $display("FAIL sweep_hold: got %0d want %0d", o_Select, held); end
    end
    hold(1'b0, 1'b1, 5);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Paused === 1'b0) found = 1;
    end
    n_checks++; if (found != 1) begin n_fail++; $display("FAIL sweep_resume: paused %0d want 0", o_Paused); end
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (o_Select !== 2'(m_level) || o_Paused !== m_paused) begin
        n_fail++; $display("FAIL sweep_after_resume: sel %0d paused %0d want sel %0d paused %0d", o_Select, o_Paused, m_level, m_paused);
      end
    end
  endtask

  task automatic test_bounce();
    int exp_seq[16] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int found;
    cyc(1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 4); hold(1'b0, 1'b0, 4); hold(1'b1, 1'b0, 4);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Mode === 2'd2) found = 1;
    end
    n_checks++; if (found != 1 || o_Select !== 2'd0) begin n_fail++; $display("FAIL bounce_enter: mode %0d sel %0d want mode 2 sel 0", o_Mode, o_Select); end
    for (int t = 0; t < 16; t++) begin
      logic [1:0] prev;
      prev = o_Select;
      hold(1'b0, 1'b0, ST - 1);
      n_checks++; if (o_Select !== prev) begin n_fail++; $display("FAIL bounce_early: got %0d want %0d", o_Select, prev); end
      cyc(1'b0, 1'b0, 1'b0);
      n_checks++; if (o_Select !== 2'(exp_seq[t])) begin n_fail++; $display("FAIL bounce_step%0d: got %0d want %0d", t, o_Select, exp_seq[t]); end
    end
  endtask

  task automatic test_simultaneous();
    int found;
    cyc(1'b1, 1'b0, 1'b0);
    hold(1'b0, 1'b1, 6); hold(1'b0, 1'b0, 8);
    n_checks++; if (o_Select !== 2'd1) begin n_fail++; $display("FAIL simul_start: got %0d want 1", o_Select); end
    hold(1'b1, 1'b1, 6);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Mode !== 2'd0) found = 1;
    end
    n_checks++; if (o_Mode !== 2'd1) begin n_fail++; $display("FAIL simul_mode: got %0d want 1", o_Mode); end
    n_checks++; if (o_Select !== 2'd1) begin n_fail++; $display("FAIL simul_sel: got %0d want 1", o_Select); end
    n_checks++; if (o_Paused !== 1'b0) begin n_fail++; $display("FAIL simul_paused: got %0d want 0", o_Paused); end
  endtask

  task automatic test_reset_mid();
    int found;
    cyc(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin hold(1'b0, 1'b1, 6); hold(1'b0, 1'b0, 8); end
    hold(1'b1, 1'b0, 4); hold(1'b0, 1'b0, 4); hold(1'b1, 1'b0, 4); hold(1'b0, 1'b1, 4);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Paused === 1'b1) found = 1;
    end
    n_checks++;
    if (found != 1 || o_Mode !== 2'd2 || o_Select !== 2'd3) begin
      n_fail++; $display("FAIL rstmid_setup: mode %0d sel %0d paused %0d want 2 3 1", o_Mode, o_Select, o_Paused);
    end
    hold(1'b1, 1'b0, 2);
    cyc(1'b1, 1'b1, 1'b0);
    n_checks++; if (o_Select !== 2'd0) begin n_fail++; $display("FAIL rstmid_sel: got %0d want 0", o_Select); end
    n_checks++; if (o_Mode !== 2'd0) begin n_fail++; $display("FAIL rstmid_mode: got %0d want 0", o_Mode); end
    n_checks++; if (o_Paused !== 1'b0) begin n_fail++; $display("FAIL rstmid_paused: got %0d want 0", o_Paused); end
    n_checks++; if (leds !== 4'b0001) begin n_fail++; $display("FAIL rstmid_leds: got %b want 0001", leds); end
    hold(1'b1, 1'b0, DL - 1);
    hold(1'b0, 1'b0, 10);
    n_checks++; if (o_Mode !== 2'd0) begin n_fail++; $display("FAIL rstmid_carry: mode %0d want 0", o_Mode); end
    hold(1'b1, 1'b0, DL);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (o_Mode === 2'd1) found = 1;
    end
    n_checks++; if (found != 1) begin n_fail++; $display("FAIL rstmid_full: mode %0d want 1", o_Mode); end
  endtask

  task automatic test_random();
    logic s1, s2, r;
    int len;
    cyc(1'b1, 1'b0, 1'b0);
    for (int seg = 0; seg < 500; seg++) begin
      s1 = ($urandom_range(0, 3) == 0);
      s2 = ($urandom_range(0, 1) == 0);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 299) == 0);
        cyc(r, s1, s2);
        n_checks++;
        if (o_Select !== 2'(m_level) || o_Mode !== 2'(m_mode) || o_Paused !== m_paused || leds !== therm(m_level)) begin
          n_fail++;
          $display("FAIL random t=%0t: sel %0d mode %0d paused %0d leds %b want sel %0d mode %0d paused %0d leds %b",
                   $time, o_Select, o_Mode, o_Paused, leds, m_level, m_mode, m_paused, therm(m_level));
        end
      end
    end
  endtask

  initial begin
    i_Rst = 1'b1; i_Switch_1 = 1'b0; i_Switch_2 = 1'b0;
    test_reset();
    test_manual();
    test_glitch();
    test_sweep_pause();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_level_sequencer.md
# led_level_sequencer

Controller for the Go Board 4-LED thermometer bar. It debounces both board switches and turns their release events into a 2-bit level select. The select is produced in one of three modes: manual stepping, automatic wrap-around sweep, or ping-pong bounce. It replaces raw switch wiring to the level latch: the LED bar shows `o_Select` as a thermometer code, and `o_Mode`/`o_Paused` expose controller state for other LEDs or displays.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required before a debounced switch changes (10 ms at 25 MHz); legal range ≥ 2.
- `STEP_TICKS`, default 12500000: cycles per automatic level step (0.5 s at 25 MHz); legal range ≥ 2.
- `i_Clk` in 1: system clock; sole clock domain.
- `i_Rst` in 1: synchronous, active-high reset.
- `i_Switch_1` in 1: raw switch, active-high; release cycles the mode.
- `i_Switch_2` in 1: raw switch, active-high; release steps the level (manual) or toggles pause (auto modes).
- `o_Select` out 2: current level, 0..3.
- `o_Mode` out 2: 00 MANUAL, 01 SWEEP, 10 BOUNCE; 11 never driven.
- `o_Paused` out 1: auto stepping frozen.
- `o_LED_1`..`o_LED_4` out 1 each: thermometer decode of `o_Select`. Level 0 → 0001, 1 → 0011, 2 → 0111, 3 → 1111 (`o_LED_1` is the LSB).

## Operation
- **Debouncer (one per switch).**
  - Counter clears whenever raw equals debounced.
  - While raw differs from debounced, the counter increments.
  - When the counter reaches `DEBOUNCE_LIMIT-1` with raw still differing, debounced takes raw and the counter clears.
  - A glitch shorter than `DEBOUNCE_LIMIT` cycles produces no change.
- **Release event.** Registered one-cycle pulse when debounced goes 1→0. Presses (0→1) generate no event.
- **Mode FSM.** SW1 release steps MANUAL → SWEEP → BOUNCE → MANUAL.
  - Every mode change clears the tick counter, clears pause, and sets direction to up.
  - The level is retained across mode changes.
- **MANUAL.** SW2 release sets level to (level+1) mod 4, so 3 wraps to 0. Tick counter is held at 0.
- **SWEEP.**
  - Tick counter counts 0..`STEP_TICKS-1`. At terminal count it returns to 0 and level becomes (level+1) mod 4.
  - SW2 release toggles pause. While paused, both the counter and the level hold.
- **BOUNCE.** Same tick and pause rules as SWEEP, but the level follows 0,1,2,3,2,1,0,1…
  - Direction flips to down when stepping into 3, and to up when stepping into 0.
  - A step never leaves the range 0..3.
- **Simultaneous SW1 and SW2 release in the same cycle.** The mode change wins and the SW2 event is dropped.
- **SW2 release coinciding with terminal count in SWEEP or BOUNCE.**
  - Unpaused → paused: the step is still taken and pause is set.
  - Paused → unpaused: no step in that cycle and the counter starts from its held value.
- **Reset** (asserted on any edge, including mid-debounce or mid-sweep) forces:
  - level 0, MANUAL, unpaused, direction up;
  - both debounced states 0 and both debounce counters 0;
  - event pulses 0 and tick counter 0.
  - Outputs after reset: `o_Select`=00, `o_Mode`=00, `o_Paused`=0, LEDs = 0001.

## Timing
- Raw switch changes, then is held stable:
  - debounced updates on the `DEBOUNCE_LIMIT`-th rising edge after the change;
  - the event pulse is high after the next edge;
  - level/mode/pause update on the edge after that.
  - Total: `DEBOUNCE_LIMIT`+2 edges from raw release to output change.
- `o_Select`, `o_Mode`, and `o_Paused` are registers. LEDs are a combinational decode of the level register, so they change in the same cycle as `o_Select`.
- **Auto step period.**
  - Exactly `STEP_TICKS` cycles between consecutive `o_Select` changes while unpaused.
  - The first step after entering SWEEP/BOUNCE occurs `STEP_TICKS` cycles after the mode update.
- **Reset to operation.** Reset takes effect on the edge where `i_Rst`=1. The first cycle with `i_Rst`=0 resumes normal operation from reset state, with no extra idle cycles.

## Test plan
Bench parameters: `DEBOUNCE_LIMIT`=4, `STEP_TICKS`=8.
1. **Reset, manual stepping and wrap.** Reset, then press/release SW2 five times, each phase held 10 cycles.
   - After reset: `o_Select`=0, LEDs 0001, `o_Mode`=00.
   - After the releases: `o_Select` goes 1,2,3,0,1 and LEDs follow 0011,0111,1111,0001,0011.
   - Each change occurs 6 edges after raw release.
2. **Glitch rejection.** 3-cycle SW2 press, then 3-cycle release pulses → no event and `o_Select` unchanged. A 4-cycle stable press/release → exactly one step.
3. **SWEEP stepping and pause.** From level 2, release SW1 → `o_Mode`=01.
   - `o_Select` reads 3, 0, 1 at mode-update+8, +16, +24 cycles.
   - A SW2 release then sets `o_Paused`=1 and `o_Select` holds for ≥ 30 cycles.
   - A second SW2 release resumes from the held counter.
4. **BOUNCE sequence.** From MANUAL level 0, release SW1 twice → `o_Mode`=10. `o_Select` sequence over 16 ticks: 1,2,3,2,1,0,1,2,3,2,1,0,1,2,3,2. The value 3 is never exceeded and 0 is never underflowed.
5. **Simultaneous release.** In MANUAL at level 1, release SW1 and SW2 raw on the same cycle → `o_Mode`=01, `o_Select` stays 1, `o_Paused`=0.
6. **Reset mid-operation.** In BOUNCE, paused, level 3, with SW1 partially debounced, assert `i_Rst` for 1 cycle.
   - Next cycle: `o_Select`=0, `o_Mode`=00, `o_Paused`=0, LEDs 0001.
   - The earlier partial debounce count does not carry over: a later SW1 release still needs the full 4 stable cycles.
